// File: rtl/ofm_writer.sv
// Output feature map writer: saturates accumulator results to 8 bits, packs four
// per 32-bit word, writes sequential addresses and flags frame completion.
module ofm_writer #(
  parameter int ACC_W = 16,
  parameter int WORDS = 128,
  parameter bit RELU  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [ACC_W-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic [8:0]       address,
  output logic [31:0]      wrData,
  output logic             wr,
  output logic             done,
  output logic [31:0]      number
);

  typedef enum logic [1:0] {IDLE, RUN, LAST_WR, DONE} state_t;

  localparam logic signed [ACC_W-1:0] MAXV     = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] MINV     = ACC_W'(-128);
  localparam logic [7:0]              LAST_PTR = 8'(WORDS - 1);

  state_t      state;
  logic [1:0]  lane;
  logic [7:0]  word_ptr;
  logic [31:0] packed_word;

  logic [7:0]  sat_byte;
  logic [31:0] word_next;
  logic        accept;
  logic        close_word;
  logic        frame_end;

  assign in_ready   = (state == RUN);
  assign accept     = in_valid && in_ready;
  assign close_word = accept && ((lane == 2'd3) || in_last);
  assign frame_end  = close_word && (in_last || (word_ptr == LAST_PTR));

  always_comb begin
    sat_byte = in_data[7:0];
    if (RELU && in_data[ACC_W-1])
      sat_byte = '0;
    else if ($signed(in_data) > MAXV)
      sat_byte = 8'h7F;
    else if ($signed(in_data) < MINV)
      sat_byte = 8'h80;
  end

  always_comb begin
    word_next = packed_word;
    word_next[lane*8 +: 8] = sat_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      lane        <= '0;
      word_ptr    <= '0;
      packed_word <= '0;
      address     <= '0;
      wrData      <= '0;
      wr          <= 1'b0;
      done        <= 1'b0;
      number      <= '0;
    end else begin
      wr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            word_ptr    <= '0;
            lane        <= '0;
            packed_word <= '0;
          end
        end
        RUN: begin
          if (close_word) begin
            // The closing element goes straight into the emitted word so
            // the write lands one cycle after acceptance.
            wr          <= 1'b1;
            address     <= {1'b0, word_ptr};
            wrData      <= word_next;
            word_ptr    <= word_ptr + 8'd1;
            lane        <= '0;
            packed_word <= '0;
            if (frame_end)
              state <= LAST_WR;
          end else if (accept) begin
            packed_word <= word_next;
            lane        <= lane + 2'd1;
          end
        end
        LAST_WR: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          if (start) begin
            state       <= RUN;
            done        <= 1'b0;
            number      <= number + 32'd1;
            word_ptr    <= '0;
            lane        <= '0;
            packed_word <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_writer.sv
// Scoreboard bench for ofm_writer: two instances (ReLU on/off) share stimulus;
// expected words are queued at stimulus time and popped on each write strobe.
module tb_ofm_writer;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last;
  logic [15:0] in_data;
  logic        in_ready1, in_ready0, wr1, wr0, done1, done0;
  logic [8:0]  addr1, addr0;
  logic [31:0] data1, data0, num1, num0;

  typedef struct {
    logic [8:0]  a;
    logic [31:0] d1;
    logic [31:0] d0;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  ofm_writer #(.ACC_W(16), .WORDS(128), .RELU(1'b1)) u_relu (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready1), .address(addr1), .wrData(data1),
    .wr(wr1), .done(done1), .number(num1)
  );

  ofm_writer #(.ACC_W(16), .WORDS(128), .RELU(1'b0)) u_sat (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready0), .address(addr0), .wrData(data0),
    .wr(wr0), .done(done0), .number(num0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input int a, input logic [31:0] d1, input logic [31:0] d0);
    exp_t e;
    e.a = 9'(a); e.d1 = d1; e.d0 = d0;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (wr1 || wr0) begin
      check("wr_match", {31'd0, wr0}, {31'd0, wr1});
      if (exp_q.size() == 0) begin
        check("unexpected_wr", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("address", {23'd0, addr1}, {23'd0, e.a});
        check("wrData_relu", data1, e.d1);
        check("wrData_sat", data0, e.d0);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    int unsigned n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready1 && n < 20) begin step(); n++; end
    check("accept_wait", {31'd0, in_ready1}, 32'd1);
    if (in_ready1) step();
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Called right after the final element is accepted: final write is in flight.
  task automatic frame_end(input int num);
    check("ready_after_last", {31'd0, in_ready1}, 32'd0);
    check("done_during_wr", {31'd0, done1}, 32'd0);
    step();
    check("done_rise", {31'd0, done1}, 32'd1);
    check("no_wr_with_done", {31'd0, wr1}, 32'd0);
    check("number", num1, 32'(num));
  endtask

  function automatic logic [31:0] ramp_word(input int w);
    logic [7:0] b;
    b = 8'((4 * w) % 128);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    step(); step();
    check("rst_in_ready", {31'd0, in_ready1}, 32'd0);
    check("rst_wr", {31'd0, wr1}, 32'd0);
    check("rst_done", {31'd0, done1}, 32'd0);
    check("rst_address", {23'd0, addr1}, 32'd0);
    check("rst_wrData", data1, 32'd0);
    check("rst_number", num1, 32'd0);
    rst = 1'b0;
    step();
    check("idle_in_ready", {31'd0, in_ready1}, 32'd0);

    // Frame 0: full 128-word ramp, back-to-back
    pulse_start();
    for (int i = 0; i < 512; i++) begin
      if (i % 4 == 3) push(i / 4, ramp_word(i / 4), ramp_word(i / 4));
      send(16'(i % 128), i == 511);
    end
    frame_end(0);

    // Frame 1: saturation, lane 3 carries in_last
    pulse_start();
    check("done_cleared", {31'd0, done1}, 32'd0);
    check("number_inc", num1, 32'd1);
    push(0, 32'h7F7F007F, 32'h7F7FFB7F);
    send(16'd300, 1'b0);
    send(16'hFFFB, 1'b0);
    send(16'd127, 1'b0);
    send(16'd128, 1'b1);
    frame_end(1);

    // Frame 2: partial word, then elements presented after the frame
    pulse_start();
    push(0, 32'h14131211, 32'h14131211);
    push(1, 32'h00001615, 32'h00001615);
    for (int i = 0; i < 6; i++) send(16'(8'h11 + i), i == 5);
    frame_end(2);
    in_valid = 1'b1; in_data = 16'h0055;
    step(); step(); step();
    check("ready_in_done", {31'd0, in_ready1}, 32'd0);
    in_valid = 1'b0;

    // Frame 3: gapped input with an ignored mid-frame start
    pulse_start();
    push(0, 32'h24232221, 32'h24232221);
    push(1, 32'h28272625, 32'h28272625);
    for (int i = 0; i < 8; i++) begin
      send(16'(8'h21 + i), i == 7);
      if (i == 7) break;
      if (i == 2) start = 1'b1;
      step();
      start = 1'b0;
    end
    frame_end(3);

    // Frame 4: aborted by reset after two elements
    pulse_start();
    send(16'h0001, 1'b0);
    send(16'h0002, 1'b0);
    rst = 1'b1;
    step();
    check("mid_rst_in_ready", {31'd0, in_ready1}, 32'd0);
    check("mid_rst_wr", {31'd0, wr1}, 32'd0);
    check("mid_rst_done", {31'd0, done1}, 32'd0);
    check("mid_rst_address", {23'd0, addr1}, 32'd0);
    check("mid_rst_wrData", data1, 32'd0);
    check("mid_rst_number", num1, 32'd0);
    rst = 1'b0;
    step(); step();
    pulse_start();
    push(0, 32'h34333231, 32'h34333231);
    for (int i = 0; i < 4; i++) send(16'(8'h31 + i), i == 3);
    frame_end(0);

    step(); step();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/ofm_writer.md
Name: ofm_writer

Overview:
- Upstream neighbour of the output feature map memory: takes the accumulator result stream and drives the memory's write port (address, wrData, wr), the done flag and the frame number.
- Saturates each signed accumulator result to 8 bits, with optional ReLU.
- Packs four results into one 32-bit word and writes the words at sequential addresses.
- Raises done once a frame is complete, so the memory can dump the frame.

Parameters:
- ACC_W, 16, width of signed accumulator input element
- WORDS, 128, maximum words per frame (memory depth)
- RELU, 1, 1 = negative results forced to 0 before saturation; 0 = signed saturation only

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  single-cycle request to begin a frame
- in_valid  input  1  accumulator element valid
- in_data  input  ACC_W  signed accumulator element
- in_last  input  1  marks final element of frame (qualified by in_valid)
- in_ready  output  1  element accepted when in_valid && in_ready
- address  output  9  word address to memory (bit 8 always 0)
- wrData  output  32  packed word to memory
- wr  output  1  memory write strobe, one cycle per word
- done  output  1  frame complete, level, held until next start
- number  output  32  current frame index

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; in_ready=0, wr=0, done=0, address=0, wrData=0, number=0.
  - Lane index and word pointer are cleared.
  - Applies from any state, including mid-frame; a partially packed word is discarded.
- States: IDLE, RUN, LAST_WR, DONE.
- IDLE:
  - in_ready=0.
  - start -> RUN; word_ptr=0, lane=0; number unchanged.
- RUN:
  - in_ready=1 (combinational on state).
  - On accept: element conversion:
    - If RELU and in_data<0 -> 0.
    - Else clamp signed to [-128,127].
    - Take low 8 bits.
  - Packing: lane 0 goes to bits [7:0], lane 1 to [15:8], lane 2 to [23:16], lane 3 to [31:24].
- Word emit:
  - Triggered on accepting lane 3, or on accepting any element with in_last=1.
  - Next cycle: wr=1, address=word_ptr, wrData=packed word. Unfilled lanes are 0.
  - After the emit, word_ptr increments and lane returns to 0.
  - Latency from accepting the closing element to wr is 1 cycle.
  - Full throughput: in_ready stays high during a write; back-to-back elements are legal.
- Frame end (RUN -> LAST_WR):
  - Happens when the emitted word carries in_last, or when its word_ptr == WORDS-1.
  - in_ready drops to 0 in the cycle wr of the final word is high.
  - Elements presented after frame end are not accepted.
- LAST_WR:
  - wr=1 for the final word.
  - Next cycle -> DONE with done=1.
  - done is never high in the same cycle as any wr, so the memory holds the final word before done is seen.
- DONE:
  - done=1, in_ready=0, wr=0.
  - start: done=0, number=number+1, word_ptr=0, lane=0 -> RUN.
- Start while in RUN or LAST_WR is ignored.
- in_last with lane 3 emits one word, not two.
- Words beyond the last written word are not touched (no zero-fill of the memory).
- wr is 0 in every cycle except an emit cycle. address and wrData hold their last value when wr=0.
- number wraps modulo 2^32.

Test Plan:
- Reset, then start; stream 512 elements 0..127 repeating, in_valid held high, in_last on element 511.
  - Expect 128 wr pulses at addresses 0..127; word 0 = 0x03020100.
  - done rises 1 cycle after the final wr.
  - number=0.
- Saturation, RELU=1; inputs 300, -5, 127, 128 in one word.
  - Expect wrData=0x7F7F007F.
- Same inputs with RELU=0.
  - Expect wrData=0x7F7FFB7F.
- Partial word: 6 elements 0x11..0x16, in_last on the 6th.
  - Expect wr at address 0 = 0x14131211, then address 1 = 0x00001615.
  - done 1 cycle later; in_ready=0 afterwards.
- Gapped in_valid (every other cycle) over 8 elements.
  - Expect identical words to the gap-free run; wr only one cycle after each 4th accept.
  - start pulsed mid-frame is ignored.
- Second frame from DONE via start.
  - Expect done cleared the next cycle, number=1, addresses restart at 0.
- Assert rst mid-frame after 2 accepted elements.
  - Expect all outputs 0 and no wr for the discarded lanes.
  - A fresh start then writes address 0 first.
